// File: rtl/symbol_downsampler_if.sv
// I/Q sample and symbol bundle for the receive decimator.
// Master drives the sample stream; slave returns symbols.
interface symbol_downsampler_if #(
  parameter int W = 4
);
  logic signed [W-1:0] iin;
  logic signed [W-1:0] qin;
  logic signed [W-1:0] idown;
  logic signed [W-1:0] qdown;
  logic                dvalid;
  logic                locked;

  modport master (
    output iin,
    output qin,
    input  idown,
    input  qdown,
    input  dvalid,
    input  locked
  );

  modport slave (
    input  iin,
    input  qin,
    output idown,
    output qdown,
    output dvalid,
    output locked
  );
endinterface

// File: rtl/symbol_downsampler.sv
// Zero-stuffed I/Q decimator: acquires phase on first non-zero.
// Loss-of-lock detect under SYMBOL_DOWNSAMPLER_LOSS_DET_EN.
module symbol_downsampler #(
  parameter int DECIM      = 11,
  parameter int W          = 4,
  parameter int LOSS_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  symbol_downsampler_if.slave  bus
);

  localparam int CW = $clog2(DECIM);
  localparam logic [CW-1:0] CMAX = CW'(DECIM - 1);
  localparam logic [CW-1:0] CONE = CW'(1);

  if (DECIM < 2) begin : g_bad_decim
    $error("DECIM must be at least 2");
  end
  if (LOSS_COUNT < 1) begin : g_bad_loss
    $error("LOSS_COUNT must be at least 1");
  end

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          lock_n;
  logic          cap;
  logic          nz;
  logic          sym;

  assign nz  = (bus.iin != '0) || (bus.qin != '0);
  assign sym = (cnt == '0);

`ifdef SYMBOL_DOWNSAMPLER_LOSS_DET_EN
  localparam int ZW = $clog2(LOSS_COUNT + 1);
  localparam logic [ZW-1:0] ZLAST = ZW'(LOSS_COUNT - 1);
  localparam logic [ZW-1:0] ZONE  = ZW'(1);

  logic [ZW-1:0] zrun, zrun_n;

  // Zero-run counter of consecutive empty symbol samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zrun <= '0;
    end else begin
      zrun <= zrun_n;
    end
  end
`endif

  // Phase state and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEARCH;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, phase count and capture decision
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lock_n  = bus.locked;
    cap     = 1'b0;
`ifdef SYMBOL_DOWNSAMPLER_LOSS_DET_EN
    zrun_n  = zrun;
`endif
    unique case (state)
      SEARCH: begin
        cnt_n = '0;
        if (nz) begin
          cap     = 1'b1;
          cnt_n   = CONE;
          lock_n  = 1'b1;
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        cnt_n = (cnt == CMAX) ? '0 : cnt + CONE;
        if (sym) begin
          cap = 1'b1;
`ifdef SYMBOL_DOWNSAMPLER_LOSS_DET_EN
          if (!nz) begin
            if (zrun == ZLAST) begin
              cap     = 1'b0;
              lock_n  = 1'b0;
              cnt_n   = '0;
              zrun_n  = '0;
              state_n = SEARCH;
            end else begin
              zrun_n = zrun + ZONE;
            end
          end else begin
            zrun_n = '0;
          end
`endif
        end
      end
      default: begin
        state_n = SEARCH;
        cnt_n   = '0;
        lock_n  = 1'b0;
      end
    endcase
  end

  // Registered symbol outputs, strobe and lock flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.idown  <= '0;
      bus.qdown  <= '0;
      bus.dvalid <= 1'b0;
      bus.locked <= 1'b0;
    end else begin
      bus.dvalid <= cap;
      bus.locked <= lock_n;
      if (cap) begin
        bus.idown <= bus.iin;
        bus.qdown <= bus.qin;
      end
    end
  end

endmodule

// File: tb/tb_symbol_downsampler.sv
// Randomized bench for symbol_downsampler against a
// timeline-based reference model.
module tb_symbol_downsampler;

  localparam int DECIM      = 11;
  localparam int W          = 4;
  localparam int LOSS_COUNT = 4;

  logic clk = 1'b0;
  logic reset;

  symbol_downsampler_if #(.W(W)) bus();

  symbol_downsampler #(
    .DECIM(DECIM),
    .W(W),
    .LOSS_COUNT(LOSS_COUNT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: lock flag, acquisition time, zero run
  int t      = 0;
  int anchor = 0;
  int zr     = 0;
  bit mlk    = 0;
  bit ev     = 0;
  int ei     = 0;
  int eq     = 0;

  bit collect = 0;
  int got_i[$];
  int got_q[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    mlk = 0; ev = 0; ei = 0; eq = 0; zr = 0;
  endtask

  task automatic model_edge(input int i, input int q);
    bit z;
    z  = (i == 0) && (q == 0);
    ev = 0;
    if (!mlk) begin
      if (!z) begin
        mlk = 1; anchor = t; zr = 0;
        ev = 1; ei = i; eq = q;
      end
    end else if (((t - anchor) % DECIM) == 0) begin
`ifdef SYMBOL_DOWNSAMPLER_LOSS_DET_EN
      if (z) zr++;
      else zr = 0;
      if (zr == LOSS_COUNT) begin
        mlk = 0; zr = 0;
      end else begin
        ev = 1; ei = i; eq = q;
      end
`else
      ev = 1; ei = i; eq = q;
`endif
    end
  endtask

  task automatic step(input int i, input int q);
    bus.iin = W'(i);
    bus.qin = W'(q);
    @(posedge clk);
    model_edge(i, q);
    t++;
    #1;
    check("dvalid", int'(bus.dvalid), int'(ev));
    check("locked", int'(bus.locked), int'(mlk));
    check("idown", int'(bus.idown), ei);
    check("qdown", int'(bus.qdown), eq);
    if (collect && bus.dvalid) begin
      got_i.push_back(int'(bus.idown));
      got_q.push_back(int'(bus.qdown));
    end
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_idown", int'(bus.idown), 0);
    check("rst_qdown", int'(bus.qdown), 0);
    check("rst_dvalid", int'(bus.dvalid), 0);
    check("rst_locked", int'(bus.locked), 0);
    @(posedge clk);
    #4;
    reset = 1'b1;
  endtask

  function automatic int rnd_sym();
    int v;
    v = 2 * int'($urandom_range(0, 3)) - 3;
    return v;
  endfunction

  initial begin
    int pts_i[16];
    int pts_q[16];
    int n;
    reset   = 1'b0;
    bus.iin = '0;
    bus.qin = '0;
    #12;
    check("init_idown", int'(bus.idown), 0);
    check("init_qdown", int'(bus.qdown), 0);
    check("init_dvalid", int'(bus.dvalid), 0);
    check("init_locked", int'(bus.locked), 0);
    reset = 1'b1;

    // acquisition
    for (int k = 0; k < 5; k++) step(0, 0);
    step(3, -1);
    check("acq_i", int'(bus.idown), 3);
    check("acq_q", int'(bus.qdown), -1);
    check("acq_v", int'(bus.dvalid), 1);
    for (int k = 0; k < 10; k++) step(0, 0);
    step(-3, 1);
    check("acq2_v", int'(bus.dvalid), 1);
    check("acq2_i", int'(bus.idown), -3);
    check("acq2_q", int'(bus.qdown), 1);

    // stray sample at phase 5, then the grid continues
    for (int k = 0; k < 2 * DECIM; k++) begin
      if (((t - anchor) % DECIM) == 5) step(1, 0);
      else if (((t - anchor) % DECIM) == 0) step(1, 3);
      else step(0, 0);
    end

    // async reset mid-stream, then zeros stay silent
    do_reset();
    for (int k = 0; k < 15; k++) step(0, 0);

    // loss of lock
    step(3, 3);
    for (int k = 0; k < LOSS_COUNT * DECIM; k++) step(0, 0);
`ifdef SYMBOL_DOWNSAMPLER_LOSS_DET_EN
    check("loss_locked", int'(bus.locked), 0);
    check("loss_dvalid", int'(bus.dvalid), 0);
`else
    check("keep_locked", int'(bus.locked), 1);
    check("keep_dvalid", int'(bus.dvalid), 1);
`endif
    n = $urandom_range(1, 20);
    for (int k = 0; k < n; k++) step(0, 0);
    step(2, 0);
`ifdef SYMBOL_DOWNSAMPLER_LOSS_DET_EN
    check("reacq_i", int'(bus.idown), 2);
`endif

    // loopback from an ideal upsampler
    do_reset();
    for (int k = 0; k < 16; k++) begin
      pts_i[k] = 2 * (k / 4) - 3;
      pts_q[k] = 2 * (k % 4) - 3;
    end
    collect = 1;
    for (int k = 0; k < 16; k++) begin
      step(pts_i[k], pts_q[k]);
      for (int j = 1; j < DECIM; j++) step(0, 0);
    end
    collect = 0;
    check("loop_count", got_i.size(), 16);
    for (int k = 0; k < 16 && k < got_i.size(); k++) begin
      check("loop_i", got_i[k], pts_i[k]);
      check("loop_q", got_q[k], pts_q[k]);
    end

    // random: zero-stuffed symbols, dropouts, noise
    for (int r = 0; r < 1200; r++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 8) begin
        step(rnd_sym(), rnd_sym());
      end else if (sel < 12) begin
        step(int'($urandom_range(0, 15)) - 8,
             int'($urandom_range(0, 15)) - 8);
      end else if (sel < 14) begin
        do_reset();
      end else if (mlk && ((t - anchor) % DECIM) == 0
                   && sel < 80) begin
        step(rnd_sym(), rnd_sym());
      end else begin
        step(0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/symbol_downsampler.md
# symbol_downsampler

Receive-side decimator for the QAM-16 I/Q chain. It takes the zero-stuffed, one-sample-per-clock I/Q stream (one symbol followed by DECIM-1 zeros) and acquires the symbol phase from the first non-zero sample. It then emits one registered I/Q symbol per DECIM clocks with a valid strobe. It is the inverse of the transmit upsampler and sits between the channel/filter path and the QAM-16 demapper.

## Interface
- DECIM, 11, samples per symbol (≥2); phase counter width is $clog2(DECIM).
- W, 4, signed sample width of I and Q.
- LOSS_COUNT, 4, consecutive all-zero symbol-phase samples that declare loss of lock (used only with the macro, ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iin  in  W  signed in-phase sample, one per clock.
- qin  in  W  signed quadrature sample, one per clock.
- idown  out  W  signed decimated in-phase symbol, registered.
- qdown  out  W  signed decimated quadrature symbol, registered.
- dvalid  out  1  one-cycle strobe; idown/qdown carry a new symbol.
- locked  out  1  high while the symbol phase is acquired.

## Operation
- Reset values: idown=0, qdown=0, dvalid=0, locked=0, phase count=0, zero-run counter=0, state SEARCH.
- SEARCH:
  - Count is held at 0.
  - Any sample with iin≠0 or qin≠0 (I alone or Q alone suffices) does all of the following on the same edge: capture to idown/qdown, pulse dvalid, set count=1, set locked=1, go to LOCKED.
  - All-zero samples produce no dvalid.
- LOCKED:
  - Count increments and wraps from DECIM-1 to 0.
  - At count==0, the input is the symbol sample. Capture it to idown/qdown and pulse dvalid, whatever its value.
  - At count≠0, input is ignored, including stray non-zero values. No dvalid, and outputs hold.
- Outputs hold their last symbol between strobes. dvalid is never high on two consecutive cycles, because DECIM≥2.
- No arithmetic is applied to samples; values pass bit-exact. Valid QAM-16 symbols are non-zero (±1, ±3 per axis), so an all-zero symbol sample indicates lost alignment.

## Timing
- Latency is one clock. A sample present before edge N appears on idown/qdown after edge N, with dvalid high for the cycle following edge N.
- After acquisition, strobes are spaced exactly DECIM clocks apart.
- Reset low asynchronously clears all state and outputs mid-symbol. The first rising edge after release starts in SEARCH.
- With a direct upsampler→downsampler connection, symbol k appears on idown one clock after it appears on the upsampler output.

## Configuration
- SYMBOL_DOWNSAMPLER_LOSS_DET_EN defined:
  - In LOCKED, each symbol-phase sample with iin==0 and qin==0 increments the zero-run counter. A non-zero symbol-phase sample clears it.
  - The 1st through (LOSS_COUNT-1)th zero symbols are still output with dvalid (values 0).
  - On the LOSS_COUNT-th zero symbol there is no dvalid and outputs hold. On that edge locked drops to 0, the counters clear, and the state returns to SEARCH.
  - A non-zero sample on any later clock reacquires per SEARCH rules.
- Undefined: no zero-run counter is built. LOCKED is left only by reset, and zero symbol-phase samples are output as 0 with dvalid.

## Test plan
- Reset: drive reset=0 mid-stream while locked → idown=qdown=0, dvalid=0, locked=0 immediately without a clock; after release, zeros in → no dvalid.
- Acquisition: 5 zero samples, then iin=3/qin=-1, 10 zeros, then iin=-3/qin=1 → dvalid one clock after the first symbol with idown=3, qdown=-1, locked=1; next dvalid exactly 11 clocks later with idown=-3, qdown=1.
- Stray sample: locked, iin=1 at count=5 → no dvalid, idown/qdown unchanged, next strobe still on the 11-clock grid.
- Loss with macro defined (LOSS_COUNT=4): after lock on symbol 3/3, feed all zeros → three dvalid pulses with 0/0 at 11-clock spacing; locked falls on the edge 44 clocks after the good symbol with no dvalid there; next non-zero sample 2/0 at an arbitrary offset → reacquired, dvalid, idown=2.
- Macro undefined, same stimulus → locked stays 1; dvalid continues every 11 clocks with idown=qdown=0.
- Loopback: upsampler feeding this block with all 16 constellation points (±1, ±3 on each axis) in sequence → recovered symbols match input order and values exactly, 11-clock spacing, no missing or extra dvalid.
